// File: rtl/floo_nw_join_sched.sv
// Weighted scheduler for the shared wide AXI port behind the narrow/wide join.
// Two identical weighted round-robin arbiters (AW, AR) pick between the narrow
// (index 0) and wide (index 1) requesters. A small order FIFO remembers which
// side each accepted AW came from so that W beats are forwarded in AW order.
// Only selects and handshakes are produced here; payload muxing uses *_sel_o.

module floo_nw_join_sched_arb #(
    parameter int unsigned NarrowWeight = 1,
    parameter int unsigned WideWeight   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       gate_i,
    input  logic       mst_ready_i,
    output logic       mst_valid_o,
    output logic [1:0] ready_o,
    output logic       sel_o,
    output logic       lock_o
);
    localparam int unsigned MaxWeight = (NarrowWeight > WideWeight) ? NarrowWeight : WideWeight;
    localparam int unsigned CW        = $clog2(MaxWeight + 1);
    localparam logic [CW-1:0] NW      = CW'(NarrowWeight);
    localparam logic [CW-1:0] WW      = CW'(WideWeight);

    logic          prio_q, prio_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          lock_q, lock_d;
    logic          lock_sel_q, lock_sel_d;
    logic          pick_s, valid_s, hs_s;
    logic [1:0]    ready_s;

    function automatic logic [CW-1:0] weight_of(input logic side);
        if (side) begin
            return WW;
        end else begin
            return NW;
        end
    endfunction

    // Pick a side: a pending request stays on its side until it is accepted.
    always_comb begin
        pick_s = prio_q;
        if (lock_q) begin
            pick_s = lock_sel_q;
        end else if (req_i == 2'b11) begin
            pick_s = prio_q;
        end else if (req_i[0]) begin
            pick_s = 1'b0;
        end else if (req_i[1]) begin
            pick_s = 1'b1;
        end else begin
            pick_s = prio_q;
        end
        valid_s          = req_i[pick_s] & gate_i & ~rst_i;
        hs_s             = valid_s & mst_ready_i;
        ready_s          = 2'b00;
        ready_s[pick_s]  = hs_s;
    end

    assign mst_valid_o = valid_s;
    assign ready_o     = ready_s;
    assign sel_o       = rst_i ? 1'b1 : pick_s;
    assign lock_o      = lock_q;

    // Priority/credit bookkeeping on each grant, lock while a request waits.
    always_comb begin
        prio_d     = prio_q;
        credit_d   = credit_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        if (hs_s) begin
            lock_d = 1'b0;
            if (pick_s == prio_q) begin
                if (credit_q <= CW'(1)) begin
                    prio_d   = ~pick_s;
                    credit_d = weight_of(~pick_s);
                end else begin
                    credit_d = credit_q - CW'(1);
                end
            end else begin
                // Priority side was idle: the granted side takes over priority.
                if (weight_of(pick_s) == CW'(1)) begin
                    prio_d   = ~pick_s;
                    credit_d = weight_of(~pick_s);
                end else begin
                    prio_d   = pick_s;
                    credit_d = weight_of(pick_s) - CW'(1);
                end
            end
        end else if (valid_s) begin
            lock_d     = 1'b1;
            lock_sel_d = pick_s;
        end else begin
            lock_d = lock_q;
        end
    end

    // Arbiter state registers, wide side owns priority out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q     <= 1'b1;
            credit_q   <= WW;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b1;
        end else begin
            prio_q     <= prio_d;
            credit_q   <= credit_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
        end
    end
endmodule

module floo_nw_join_sched_chk #(
    parameter int unsigned NarrowWeight = 1,
    parameter int unsigned WideWeight   = 4,
    parameter int unsigned MaxWTxns     = 8
) (
    input logic clk_i,
    input logic rst_i,
    input logic push_i,
    input logic pop_i,
    input logic full_i,
    input logic empty_i,
    input logic aw_lock_i,
    input logic aw_sel_i,
    input logic ar_lock_i,
    input logic ar_sel_i
);
    logic aw_sel_prev_q, aw_sel_prev_d;
    logic ar_sel_prev_q, ar_sel_prev_d;

    // Remember last cycle's selects for the stability check.
    always_comb begin
        aw_sel_prev_d = aw_sel_i;
        ar_sel_prev_d = ar_sel_i;
    end

    // Parameter sanity, FIFO bounds and select stability while locked.
    always_ff @(posedge clk_i) begin
        aw_sel_prev_q <= aw_sel_prev_d;
        ar_sel_prev_q <= ar_sel_prev_d;
        if (!rst_i) begin
            assert (NarrowWeight >= 1);
            assert (WideWeight >= 1);
            assert (MaxWTxns >= 2);
            assert (!(push_i && full_i));
            assert (!(pop_i && empty_i));
            assert (!aw_lock_i || (aw_sel_i == aw_sel_prev_q));
            assert (!ar_lock_i || (ar_sel_i == ar_sel_prev_q));
        end
    end
endmodule

module floo_nw_join_sched #(
    parameter int unsigned NarrowWeight = 1,
    parameter int unsigned WideWeight   = 4,
    parameter int unsigned MaxWTxns     = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic narrow_aw_valid_i,
    output logic narrow_aw_ready_o,
    input  logic wide_aw_valid_i,
    output logic wide_aw_ready_o,
    output logic mst_aw_valid_o,
    input  logic mst_aw_ready_i,
    output logic aw_sel_o,
    input  logic narrow_ar_valid_i,
    output logic narrow_ar_ready_o,
    input  logic wide_ar_valid_i,
    output logic wide_ar_ready_o,
    output logic mst_ar_valid_o,
    input  logic mst_ar_ready_i,
    output logic ar_sel_o,
    input  logic narrow_w_valid_i,
    input  logic narrow_w_last_i,
    output logic narrow_w_ready_o,
    input  logic wide_w_valid_i,
    input  logic wide_w_last_i,
    output logic wide_w_ready_o,
    output logic mst_w_valid_o,
    input  logic mst_w_ready_i,
    output logic w_sel_o,
    output logic w_fifo_full_o
);
    localparam int unsigned PtrW = (MaxWTxns > 2) ? $clog2(MaxWTxns) : 1;
    localparam int unsigned CntW = $clog2(MaxWTxns + 1);

    logic [MaxWTxns-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                full_s, empty_s, head_s, push_s, pop_s, last_s;
    logic                w_valid_s, w_sel_s, n_w_ready_s, w_w_ready_s;
    logic [1:0]          aw_ready_s, ar_ready_s;
    logic                aw_lock_s, ar_lock_s;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxWTxns - 1)) begin
            return {PtrW{1'b0}};
        end else begin
            return p + PtrW'(1);
        end
    endfunction

    assign full_s  = (cnt_q == CntW'(MaxWTxns));
    assign empty_s = (cnt_q == {CntW{1'b0}});
    assign head_s  = fifo_q[rd_ptr_q];

    floo_nw_join_sched_arb #(
        .NarrowWeight(NarrowWeight),
        .WideWeight  (WideWeight)
    ) i_aw_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      ({wide_aw_valid_i, narrow_aw_valid_i}),
        .gate_i     (~full_s),
        .mst_ready_i(mst_aw_ready_i),
        .mst_valid_o(mst_aw_valid_o),
        .ready_o    (aw_ready_s),
        .sel_o      (aw_sel_o),
        .lock_o     (aw_lock_s)
    );

    floo_nw_join_sched_arb #(
        .NarrowWeight(NarrowWeight),
        .WideWeight  (WideWeight)
    ) i_ar_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      ({wide_ar_valid_i, narrow_ar_valid_i}),
        .gate_i     (1'b1),
        .mst_ready_i(mst_ar_ready_i),
        .mst_valid_o(mst_ar_valid_o),
        .ready_o    (ar_ready_s),
        .sel_o      (ar_sel_o),
        .lock_o     (ar_lock_s)
    );

    assign narrow_aw_ready_o = aw_ready_s[0];
    assign wide_aw_ready_o   = aw_ready_s[1];
    assign narrow_ar_ready_o = ar_ready_s[0];
    assign wide_ar_ready_o   = ar_ready_s[1];

    // Forward W from the side at the FIFO head; nothing moves while empty.
    always_comb begin
        w_sel_s     = 1'b1;
        w_valid_s   = 1'b0;
        n_w_ready_s = 1'b0;
        w_w_ready_s = 1'b0;
        last_s      = 1'b0;
        if (!empty_s && !rst_i) begin
            w_sel_s = head_s;
            if (head_s) begin
                w_valid_s   = wide_w_valid_i;
                w_w_ready_s = mst_w_ready_i;
                last_s      = wide_w_last_i;
            end else begin
                w_valid_s   = narrow_w_valid_i;
                n_w_ready_s = mst_w_ready_i;
                last_s      = narrow_w_last_i;
            end
        end else begin
            w_sel_s = 1'b1;
        end
    end

    assign push_s           = mst_aw_valid_o & mst_aw_ready_i;
    assign pop_s            = w_valid_s & mst_w_ready_i & last_s;
    assign mst_w_valid_o    = w_valid_s;
    assign w_sel_o          = w_sel_s;
    assign narrow_w_ready_o = n_w_ready_s;
    assign wide_w_ready_o   = w_w_ready_s;
    assign w_fifo_full_o    = full_s & ~rst_i;

    // Order FIFO update: push the AW source, pop on the last W beat.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = aw_sel_o;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Order FIFO registers, emptied by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_q   <= {MaxWTxns{1'b0}};
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
            cnt_q    <= {CntW{1'b0}};
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    floo_nw_join_sched_chk #(
        .NarrowWeight(NarrowWeight),
        .WideWeight  (WideWeight),
        .MaxWTxns    (MaxWTxns)
    ) i_chk (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (push_s),
        .pop_i    (pop_s),
        .full_i   (full_s),
        .empty_i  (empty_s),
        .aw_lock_i(aw_lock_s),
        .aw_sel_i (aw_sel_o),
        .ar_lock_i(ar_lock_s),
        .ar_sel_i (ar_sel_o)
    );
endmodule

// File: tb/tb_floo_nw_join_sched.sv
// Directed bench for floo_nw_join_sched (weights 1/4, W-order depth 8).
// Output groups are compared as 4-bit words:
//   aw/ar: {mst_valid, sel, narrow_ready, wide_ready}
//   w    : {mst_w_valid, w_sel, narrow_w_ready, wide_w_ready}
// Input groups: aw/ar {narrow_valid, wide_valid, mst_ready},
//               w {narrow_valid, narrow_last, wide_valid, wide_last, mst_ready}.

module tb_floo_nw_join_sched;
    logic clk_i = 1'b0;
    logic rst_i;
    logic narrow_aw_valid_i, wide_aw_valid_i, mst_aw_ready_i;
    logic narrow_ar_valid_i, wide_ar_valid_i, mst_ar_ready_i;
    logic narrow_w_valid_i, narrow_w_last_i, wide_w_valid_i, wide_w_last_i, mst_w_ready_i;
    logic narrow_aw_ready_o, wide_aw_ready_o, mst_aw_valid_o, aw_sel_o;
    logic narrow_ar_ready_o, wide_ar_ready_o, mst_ar_valid_o, ar_sel_o;
    logic narrow_w_ready_o, wide_w_ready_o, mst_w_valid_o, w_sel_o, w_fifo_full_o;

    int total  = 0;
    int passed = 0;

    floo_nw_join_sched #(
        .NarrowWeight(1),
        .WideWeight  (4),
        .MaxWTxns    (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .narrow_aw_valid_i(narrow_aw_valid_i),
        .narrow_aw_ready_o(narrow_aw_ready_o),
        .wide_aw_valid_i  (wide_aw_valid_i),
        .wide_aw_ready_o  (wide_aw_ready_o),
        .mst_aw_valid_o   (mst_aw_valid_o),
        .mst_aw_ready_i   (mst_aw_ready_i),
        .aw_sel_o         (aw_sel_o),
        .narrow_ar_valid_i(narrow_ar_valid_i),
        .narrow_ar_ready_o(narrow_ar_ready_o),
        .wide_ar_valid_i  (wide_ar_valid_i),
        .wide_ar_ready_o  (wide_ar_ready_o),
        .mst_ar_valid_o   (mst_ar_valid_o),
        .mst_ar_ready_i   (mst_ar_ready_i),
        .ar_sel_o         (ar_sel_o),
        .narrow_w_valid_i (narrow_w_valid_i),
        .narrow_w_last_i  (narrow_w_last_i),
        .narrow_w_ready_o (narrow_w_ready_o),
        .wide_w_valid_i   (wide_w_valid_i),
        .wide_w_last_i    (wide_w_last_i),
        .wide_w_ready_o   (wide_w_ready_o),
        .mst_w_valid_o    (mst_w_valid_o),
        .mst_w_ready_i    (mst_w_ready_i),
        .w_sel_o          (w_sel_o),
        .w_fifo_full_o    (w_fifo_full_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       rst;
        logic [2:0] aw_in;
        logic [2:0] ar_in;
        logic [4:0] w_in;
        logic [3:0] aw_exp;
        logic [3:0] ar_exp;
        logic [3:0] w_exp;
        logic       full_exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [2:0] aw, input logic [2:0] ar,
                       input logic [4:0] w, input logic [3:0] ea, input logic [3:0] er,
                       input logic [3:0] ew, input logic ef);
        vec_t v;
        v.rst = r; v.aw_in = aw; v.ar_in = ar; v.w_in = w;
        v.aw_exp = ea; v.ar_exp = er; v.w_exp = ew; v.full_exp = ef;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs at the falling edge, settle, then return.
    task automatic cyc(input logic r, input logic [2:0] aw, input logic [2:0] ar,
                       input logic [4:0] w);
        @(negedge clk_i);
        rst_i = r;
        narrow_aw_valid_i = aw[2]; wide_aw_valid_i = aw[1]; mst_aw_ready_i = aw[0];
        narrow_ar_valid_i = ar[2]; wide_ar_valid_i = ar[1]; mst_ar_ready_i = ar[0];
        narrow_w_valid_i = w[4]; narrow_w_last_i = w[3];
        wide_w_valid_i = w[2]; wide_w_last_i = w[1]; mst_w_ready_i = w[0];
        #1;
    endtask

    function automatic logic [3:0] obs_aw();
        return {mst_aw_valid_o, aw_sel_o, narrow_aw_ready_o, wide_aw_ready_o};
    endfunction
    function automatic logic [3:0] obs_ar();
        return {mst_ar_valid_o, ar_sel_o, narrow_ar_ready_o, wide_ar_ready_o};
    endfunction
    function automatic logic [3:0] obs_w();
        return {mst_w_valid_o, w_sel_o, narrow_w_ready_o, wide_w_ready_o};
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        narrow_aw_valid_i = 1'b0; wide_aw_valid_i = 1'b0; mst_aw_ready_i = 1'b0;
        narrow_ar_valid_i = 1'b0; wide_ar_valid_i = 1'b0; mst_ar_ready_i = 1'b0;
        narrow_w_valid_i = 1'b0; narrow_w_last_i = 1'b0;
        wide_w_valid_i = 1'b0; wide_w_last_i = 1'b0; mst_w_ready_i = 1'b0;

        // Reset with every request asserted: outputs quiet, selects at 1.
        add(1'b1, 3'b111, 3'b111, 5'b11111, 4'b0100, 4'b0100, 4'b0100, 1'b0);
        // Contested AW, 1/4 weights: W,W,W,W,N then W again; no same-cycle W bypass.
        add(1'b0, 3'b111, 3'b000, 5'b00001, 4'b1101, 4'b0100, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++)
            add(1'b0, 3'b111, 3'b000, 5'b00001, 4'b1101, 4'b0100, 4'b0101, 1'b0);
        add(1'b0, 3'b111, 3'b000, 5'b00001, 4'b1010, 4'b0100, 4'b0101, 1'b0);
        for (int i = 0; i < 3; i++)
            add(1'b0, 3'b111, 3'b000, 5'b00001, 4'b1101, 4'b0100, 4'b0101, 1'b0);
        // FIFO full: AW stalled even though a W last pops in the same cycle.
        add(1'b0, 3'b111, 3'b000, 5'b00111, 4'b0100, 4'b0100, 4'b1101, 1'b1);
        add(1'b0, 3'b111, 3'b000, 5'b00001, 4'b1101, 4'b0100, 4'b0101, 1'b0);
        // Drain in AW order; narrow W held off while a wide entry is at the head.
        add(1'b0, 3'b000, 3'b000, 5'b00101, 4'b0000, 4'b0100, 4'b1101, 1'b1);
        add(1'b0, 3'b000, 3'b000, 5'b00111, 4'b0000, 4'b0100, 4'b1101, 1'b1);
        add(1'b0, 3'b000, 3'b000, 5'b00111, 4'b0000, 4'b0100, 4'b1101, 1'b0);
        add(1'b0, 3'b000, 3'b000, 5'b11001, 4'b0000, 4'b0100, 4'b0101, 1'b0);
        add(1'b0, 3'b000, 3'b000, 5'b00111, 4'b0000, 4'b0100, 4'b1101, 1'b0);
        add(1'b0, 3'b000, 3'b000, 5'b10111, 4'b0000, 4'b0100, 4'b1010, 1'b0);
        add(1'b0, 3'b000, 3'b000, 5'b11111, 4'b0000, 4'b0100, 4'b1010, 1'b0);
        add(1'b0, 3'b000, 3'b000, 5'b00110, 4'b0000, 4'b0100, 4'b1100, 1'b0);
        // AR: narrow alone three times, then contested W,W,W,W,N,W and a wait.
        for (int i = 0; i < 3; i++)
            add(1'b0, 3'b000, 3'b101, 5'b00001, 4'b0000, 4'b1010, 4'b0101, 1'b0);
        for (int i = 0; i < 4; i++)
            add(1'b0, 3'b000, 3'b111, 5'b00001, 4'b0000, 4'b1101, 4'b0101, 1'b0);
        add(1'b0, 3'b000, 3'b111, 5'b00001, 4'b0000, 4'b1010, 4'b0101, 1'b0);
        add(1'b0, 3'b000, 3'b111, 5'b00001, 4'b0000, 4'b1101, 4'b0101, 1'b0);
        add(1'b0, 3'b000, 3'b110, 5'b00001, 4'b0000, 4'b1100, 4'b0101, 1'b0);
        add(1'b0, 3'b000, 3'b111, 5'b00001, 4'b0000, 4'b1101, 4'b0101, 1'b0);

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].aw_in, tbl[i].ar_in, tbl[i].w_in);
            chk($sformatf("row%0d aw", i), obs_aw(), tbl[i].aw_exp);
            chk($sformatf("row%0d ar", i), obs_ar(), tbl[i].ar_exp);
            chk($sformatf("row%0d w", i), obs_w(), tbl[i].w_exp);
            chk($sformatf("row%0d full", i), {3'b000, w_fifo_full_o}, {3'b000, tbl[i].full_exp});
        end

        // Locked AW keeps its select while the other side raises valid.
        cyc(1'b1, 3'b000, 3'b000, 5'b00000);
        cyc(1'b0, 3'b100, 3'b000, 5'b00000);
        chk("lock first", obs_aw(), 4'b1000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 3'b110, 3'b000, 5'b00000);
            chk($sformatf("lock hold%0d", i), obs_aw(), 4'b1000);
        end
        cyc(1'b0, 3'b111, 3'b000, 5'b00000);
        chk("lock release", obs_aw(), 4'b1010);
        cyc(1'b0, 3'b111, 3'b000, 5'b00000);
        chk("after lock wide", obs_aw(), 4'b1101);

        // AW narrow (2 beats) then AW wide (1 beat): W ordered N,N,W.
        cyc(1'b1, 3'b000, 3'b000, 5'b00000);
        cyc(1'b0, 3'b101, 3'b000, 5'b00111);
        chk("ord aw n", obs_aw(), 4'b1010);
        chk("ord early w", obs_w(), 4'b0100);
        cyc(1'b0, 3'b011, 3'b000, 5'b00111);
        chk("ord aw w", obs_aw(), 4'b1101);
        chk("ord wide held", obs_w(), 4'b0010);
        cyc(1'b0, 3'b000, 3'b000, 5'b10111);
        chk("ord n beat0", obs_w(), 4'b1010);
        cyc(1'b0, 3'b000, 3'b000, 5'b11111);
        chk("ord n last", obs_w(), 4'b1010);
        cyc(1'b0, 3'b000, 3'b000, 5'b00111);
        chk("ord w last", obs_w(), 4'b1101);
        cyc(1'b0, 3'b000, 3'b000, 5'b00111);
        chk("ord empty", obs_w(), 4'b0100);

        // Reset mid-traffic: FIFO depth 3, AW prio on narrow, AR locked on wide.
        cyc(1'b1, 3'b000, 3'b000, 5'b00000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 3'b011, 3'b110, 5'b00000);
            chk($sformatf("pre aw%0d", i), obs_aw(), 4'b1101);
            chk($sformatf("pre ar%0d", i), obs_ar(), 4'b1100);
        end
        cyc(1'b0, 3'b000, 3'b110, 5'b00111);
        chk("pre pop", obs_w(), 4'b1101);
        cyc(1'b1, 3'b111, 3'b111, 5'b11111);
        chk("rst aw", obs_aw(), 4'b0100);
        chk("rst ar", obs_ar(), 4'b0100);
        chk("rst w", obs_w(), 4'b0100);
        chk("rst full", {3'b000, w_fifo_full_o}, 4'b0000);
        cyc(1'b0, 3'b111, 3'b101, 5'b11111);
        chk("post aw prio", obs_aw(), 4'b1101);
        chk("post ar unlocked", obs_ar(), 4'b1010);
        chk("post w empty", obs_w(), 4'b0100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
